rd_deserializer: RTL and testbench



---
 rtl/rd_deserializer.sv | 222 ++++++++++++++++++++++
 tb/tb_rd_deserializer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_deserializer.sv
// Receiver for the RD detector serial link: requests a transfer, frames two serial
// channels of 13-bit odd-parity symbols and writes each word pair to the trace buffer.
`timescale 1ns/1ps

module rd_deserializer #(
    parameter int MEM_SIZE     = 2048,
    parameter int ADDR_WIDTH   = 11,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                  i_local_clk,
    input  logic                  i_local_rstn,
    input  logic                  i_start,
    input  logic                  i_enable_xfr,
    input  logic                  i_serial_in0,
    input  logic                  i_serial_in1,
    output logic                  o_trigger,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [25:0]           o_wr_data,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic [15:0]           o_perr_count,
    output logic                  o_timeout_err,
    output logic                  o_short_err,
    output logic                  o_overrun_err
);

    localparam int TIMER_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0]  C_TIMER_LAST = TIMER_W'(WAIT_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] C_MEM_SIZE   = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [3:0]          C_PARITY_BIT = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_enable_prev;
    logic [TIMER_W-1:0]    r_timer;
    logic [3:0]            r_bit_cnt;
    logic                  r_trigger;
    logic                  r_done;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [25:0]           r_wr_data;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic [15:0]           r_perr_count;
    logic                  r_timeout_err;
    logic                  r_short_err;
    logic                  r_overrun_err;

    logic [1:0]  w_serial;
    logic [23:0] w_word_data;
    logic [1:0]  w_perr;
    logic        w_xfr_rise;
    logic        w_timeout;
    logic        w_accept;
    logic        w_shift;
    logic        w_parity_edge;
    logic        w_frame_end;
    logic        w_room;

    assign w_serial      = {i_serial_in1, i_serial_in0};
    // A frame is only accepted on a fresh rising edge, never on a level already high.
    assign w_xfr_rise    = i_enable_xfr & ~r_enable_prev;
    assign w_timeout     = (r_timer == C_TIMER_LAST);
    assign w_accept      = (r_state == S_WAIT) && w_xfr_rise;
    assign w_shift       = (r_state == S_RECV) && i_enable_xfr && (r_bit_cnt != C_PARITY_BIT);
    assign w_parity_edge = (r_state == S_RECV) && i_enable_xfr && (r_bit_cnt == C_PARITY_BIT);
    assign w_frame_end   = (r_state == S_RECV) && !i_enable_xfr;
    assign w_room        = (r_word_count < C_MEM_SIZE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [11:0] r_shift;
            logic        r_xor;

            always_ff @(posedge i_local_clk) begin
                if (!i_local_rstn) begin
                    r_shift <= '0;
                    r_xor   <= 1'b0;
                end else if (w_accept) begin
                    r_shift <= {11'd0, w_serial[gi]};
                    r_xor   <= w_serial[gi];
                end else if (w_shift) begin
                    r_shift <= {r_shift[10:0], w_serial[gi]};
                    r_xor   <= r_xor ^ w_serial[gi];
                end else if (w_parity_edge || w_frame_end) begin
                    r_xor   <= 1'b0;
                end
            end

            assign w_word_data[gi*12 +: 12] = r_shift;
            // All 13 bits must XOR to 1; any other result flags the word.
            assign w_perr[gi] = ~(r_xor ^ w_serial[gi]);
        end
    endgenerate

    always_ff @(posedge i_local_clk) begin
        if (!i_local_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_xfr_rise) begin
                    w_state_next = S_RECV;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RECV: begin
                if (!i_enable_xfr) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_local_clk) begin
        if (!i_local_rstn) begin
            r_enable_prev <= 1'b0;
            r_timer       <= '0;
            r_bit_cnt     <= '0;
            r_trigger     <= 1'b0;
            r_done        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_word_count  <= '0;
            r_perr_count  <= '0;
            r_timeout_err <= 1'b0;
            r_short_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_enable_prev <= i_enable_xfr;
            r_done        <= 1'b0;
            r_wr_en       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_trigger     <= 1'b1;
                        r_timer       <= '0;
                        r_word_count  <= '0;
                        r_perr_count  <= '0;
                        r_timeout_err <= 1'b0;
                        r_short_err   <= 1'b0;
                        r_overrun_err <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_xfr_rise) begin
                        r_trigger <= 1'b0;
                        r_bit_cnt <= 4'd1;
                    end else if (w_timeout) begin
                        r_trigger     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_done        <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RECV: begin
                    if (!i_enable_xfr) begin
                        // Partial word at frame end is dropped, only flagged.
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != 4'd0) begin
                            r_short_err <= 1'b1;
                        end
                    end else if (r_bit_cnt == C_PARITY_BIT) begin
                        r_bit_cnt <= '0;
                        if (w_room) begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= r_word_count[ADDR_WIDTH-1:0];
                            r_wr_data    <= {w_perr, w_word_data};
                            r_word_count <= r_word_count + 1'b1;
                            if ((|w_perr) && (r_perr_count != 16'hFFFF)) begin
                                r_perr_count <= r_perr_count + 16'd1;
                            end
                        end else begin
                            r_overrun_err <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_trigger     = r_trigger;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = r_done;
    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_word_count  = r_word_count;
    assign o_perr_count  = r_perr_count;
    assign o_timeout_err = r_timeout_err;
    assign o_short_err   = r_short_err;
    assign o_overrun_err = r_overrun_err;

endmodule

// File: tb/tb_rd_deserializer.sv
// Directed bench for rd_deserializer: a fake RD sender drives framed odd-parity words
// and a write monitor collects what reaches the buffer port.
`timescale 1ns/1ps

module tb_rd_deserializer;

    localparam int MEM_SIZE = 2048;
    localparam int AW       = 11;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic          en    = 1'b0;
    logic          s0    = 1'b0;
    logic          s1    = 1'b0;
    logic          o_trigger, o_busy, o_done, o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [25:0]   o_wr_data;
    logic [AW:0]   o_word_count;
    logic [15:0]   o_perr_count;
    logic          o_timeout_err, o_short_err, o_overrun_err;

    rd_deserializer #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .WAIT_TIMEOUT(1024)) dut (
        .i_local_clk  (clk),
        .i_local_rstn (rstn),
        .i_start      (start),
        .i_enable_xfr (en),
        .i_serial_in0 (s0),
        .i_serial_in1 (s1),
        .o_trigger    (o_trigger),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_word_count (o_word_count),
        .o_perr_count (o_perr_count),
        .o_timeout_err(o_timeout_err),
        .o_short_err  (o_short_err),
        .o_overrun_err(o_overrun_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the falling edge.
    int          wr_cnt = 0, addr0_cnt = 0, perr_wr_cnt = 0, done_cnt = 0, gap_err = 0;
    int          last_wr_cyc = 0, last_done_cyc = 0, last_addr = 0;
    logic        have_prev = 1'b0;
    logic [25:0] mem [MEM_SIZE];

    always @(negedge clk) begin
        if (o_wr_en) begin
            if (have_prev && (cyc - last_wr_cyc) != 13) gap_err <= gap_err + 1;
            have_prev   <= 1'b1;
            last_wr_cyc <= cyc;
            wr_cnt      <= wr_cnt + 1;
            if (o_wr_addr == '0) addr0_cnt <= addr0_cnt + 1;
            if (o_wr_data[25] | o_wr_data[24]) perr_wr_cnt <= perr_wr_cnt + 1;
            mem[o_wr_addr] <= o_wr_data;
            last_addr   <= int'(o_wr_addr);
        end
        if (o_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (!o_busy) have_prev <= 1'b0;
    end

    logic        trig_after_first;
    logic [71:0] rst_snap;

    function automatic logic [71:0] all_outputs();
        return {o_trigger, o_busy, o_done, o_wr_en, o_wr_addr, o_wr_data, o_word_count,
                o_perr_count, o_timeout_err, o_short_err, o_overrun_err};
    endfunction

    task automatic start_xfr();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Word k: DATA0 = k, DATA1 = -k (mod 4096), odd parity; options corrupt, cut or reset.
    task automatic send_frame(input int nwords, input int bad_word, input int cut_word,
                              input int cut_bit, input int rst_word);
        logic [11:0] d0, d1;
        logic [12:0] sym0, sym1;
        for (int k = 0; k < nwords; k++) begin
            d0   = 12'(k);
            d1   = 12'(-k);
            sym0 = {d0, ~^d0};
            sym1 = {d1, ~^d1};
            if (k == bad_word) sym1[0] = ~sym1[0];
            for (int b = 0; b < 13; b++) begin
                @(negedge clk);
                if (k == cut_word && b == cut_bit) begin
                    en = 1'b0;
                    return;
                end
                if (k == 0 && b == 1) trig_after_first = o_trigger;
                if (k == rst_word && b == 5) rstn = 1'b0;
                if (k == rst_word && b == 6) begin
                    rst_snap = all_outputs();
                    rstn     = 1'b1;
                end
                en = 1'b1;
                s0 = sym0[12-b];
                s1 = sym1[12-b];
            end
        end
        @(negedge clk) en = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (all_outputs() !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, expected 0", all_outputs());
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({o_trigger, o_busy, o_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b, expected 000", {o_trigger, o_busy, o_done});
        end
        $display("reset: outputs=%h", all_outputs());
    endtask

    task automatic test_full_transfer();
        int wr0, done0, gap0;
        wr0 = wr_cnt; done0 = done_cnt; gap0 = gap_err;
        start_xfr();
        vectors++;
        if ({o_trigger, o_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL full_trigger_busy: got %b, expected 11", {o_trigger, o_busy});
        end
        send_frame(2048, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_cnt - wr0 !== 2048) begin
            miscompares++;
            $display("FAIL full_writes: got %0d, expected 2048", wr_cnt - wr0);
        end
        vectors++;
        if (mem[1] !== 26'h0FFF001) begin
            miscompares++;
            $display("FAIL full_addr1: got %h, expected 0fff001", mem[1]);
        end
        vectors++;
        if (mem[2047] !== 26'h08017FF) begin
            miscompares++;
            $display("FAIL full_addr2047: got %h, expected 08017ff", mem[2047]);
        end
        vectors++;
        if ({o_word_count, o_perr_count} !== {12'd2048, 16'd0}) begin
            miscompares++;
            $display("FAIL full_counts: got wc=%0d pc=%0d, expected wc=2048 pc=0", o_word_count, o_perr_count);
        end
        vectors++;
        if ({o_timeout_err, o_short_err, o_overrun_err, o_busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL full_flags: got %b, expected 0000", {o_timeout_err, o_short_err, o_overrun_err, o_busy});
        end
        vectors++;
        if (done_cnt - done0 !== 1) begin
            miscompares++;
            $display("FAIL full_done: got %0d pulses, expected 1", done_cnt - done0);
        end
        vectors++;
        if (trig_after_first !== 1'b0) begin
            miscompares++;
            $display("FAIL full_trigger_drop: got %b, expected 0", trig_after_first);
        end
        vectors++;
        if (gap_err - gap0 !== 0) begin
            miscompares++;
            $display("FAIL full_write_spacing: got %0d bad gaps, expected 0", gap_err - gap0);
        end
        vectors++;
        if (last_done_cyc - last_wr_cyc !== 1) begin
            miscompares++;
            $display("FAIL full_done_latency: got %0d, expected 1", last_done_cyc - last_wr_cyc);
        end
        $display("xfr full: writes=%0d wc=%0d pc=%0d", wr_cnt - wr0, o_word_count, o_perr_count);
    endtask

    task automatic test_parity_error();
        int pw0;
        pw0 = perr_wr_cnt;
        start_xfr();
        send_frame(8, 5, -1, -1, -1);
        repeat (3) @(negedge clk);
        vectors++;
        if (mem[5] !== 26'h2FFB005) begin
            miscompares++;
            $display("FAIL parity_word5: got %h, expected 2ffb005", mem[5]);
        end
        vectors++;
        if (perr_wr_cnt - pw0 !== 1) begin
            miscompares++;
            $display("FAIL parity_flagged_words: got %0d, expected 1", perr_wr_cnt - pw0);
        end
        vectors++;
        if ({o_perr_count, o_word_count} !== {16'd1, 12'd8}) begin
            miscompares++;
            $display("FAIL parity_counts: got pc=%0d wc=%0d, expected pc=1 wc=8", o_perr_count, o_word_count);
        end
        $display("xfr parity: wc=%0d pc=%0d word5=%h", o_word_count, o_perr_count, mem[5]);
    endtask

    task automatic test_short_frame();
        int wr0, done0;
        wr0 = wr_cnt; done0 = done_cnt;
        start_xfr();
        send_frame(10, -1, 3, 7, -1);
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_cnt - wr0 !== 3) begin
            miscompares++;
            $display("FAIL short_writes: got %0d, expected 3", wr_cnt - wr0);
        end
        vectors++;
        if ({o_short_err, o_timeout_err, o_overrun_err, o_word_count} !== {3'b100, 12'd3}) begin
            miscompares++;
            $display("FAIL short_status: got flags=%b wc=%0d, expected 100 wc=3",
                     {o_short_err, o_timeout_err, o_overrun_err}, o_word_count);
        end
        vectors++;
        if (done_cnt - done0 !== 1) begin
            miscompares++;
            $display("FAIL short_done: got %0d pulses, expected 1", done_cnt - done0);
        end
        $display("xfr short: writes=%0d short_err=%b", wr_cnt - wr0, o_short_err);
    endtask

    task automatic test_timeout();
        int wr0, n;
        wr0 = wr_cnt;
        n = 0;
        start_xfr();
        while (o_trigger && n < 2000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n !== 1024) begin
            miscompares++;
            $display("FAIL timeout_trigger_cycles: got %0d, expected 1024", n);
        end
        vectors++;
        if ({o_done, o_timeout_err, o_busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL timeout_status: got %b, expected 110", {o_done, o_timeout_err, o_busy});
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (wr_cnt - wr0 !== 0) begin
            miscompares++;
            $display("FAIL timeout_writes: got %0d, expected 0", wr_cnt - wr0);
        end
        $display("xfr timeout: trigger_cycles=%0d timeout_err=%b", n, o_timeout_err);
    endtask

    task automatic test_overrun();
        int wr0, a0;
        wr0 = wr_cnt; a0 = addr0_cnt;
        start_xfr();
        send_frame(2049, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_cnt - wr0 !== 2048) begin
            miscompares++;
            $display("FAIL overrun_writes: got %0d, expected 2048", wr_cnt - wr0);
        end
        vectors++;
        if (addr0_cnt - a0 !== 1 || last_addr !== 2047) begin
            miscompares++;
            $display("FAIL overrun_no_wrap: got addr0 writes=%0d last=%0d, expected 1 and 2047",
                     addr0_cnt - a0, last_addr);
        end
        vectors++;
        if ({o_overrun_err, o_short_err, o_word_count} !== {2'b10, 12'd2048}) begin
            miscompares++;
            $display("FAIL overrun_status: got ovr=%b short=%b wc=%0d, expected 1 0 2048",
                     o_overrun_err, o_short_err, o_word_count);
        end
        $display("xfr overrun: writes=%0d overrun_err=%b", wr_cnt - wr0, o_overrun_err);
    endtask

    task automatic test_reset_mid();
        int wr0, a0;
        wr0 = wr_cnt;
        rst_snap = '1;
        start_xfr();
        send_frame(150, -1, -1, -1, 100);
        repeat (3) @(negedge clk);
        vectors++;
        if (rst_snap !== 72'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h, expected 0", rst_snap);
        end
        vectors++;
        if (wr_cnt - wr0 !== 100 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_writes: got %0d busy=%b, expected 100 busy=0", wr_cnt - wr0, o_busy);
        end
        wr0 = wr_cnt; a0 = addr0_cnt;
        start_xfr();
        send_frame(4, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_cnt - wr0 !== 4 || addr0_cnt - a0 !== 1 || last_addr !== 3) begin
            miscompares++;
            $display("FAIL midreset_restart: got writes=%0d addr0=%0d last=%0d, expected 4 1 3",
                     wr_cnt - wr0, addr0_cnt - a0, last_addr);
        end
        vectors++;
        if (o_word_count !== 12'd4) begin
            miscompares++;
            $display("FAIL midreset_word_count: got %0d, expected 4", o_word_count);
        end
        $display("xfr midreset: restart writes=%0d wc=%0d", wr_cnt - wr0, o_word_count);
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_parity_error();
        test_short_frame();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
